// File: rtl/rel_cond_unit_if.sv
// Handshake bundle between the comparator bank, rel_cond_unit and the control path.
// master drives flags/cond/out_ready; slave is the condition unit.
interface rel_cond_unit_if #(
   parameter int unsigned CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic             AeqB;
   logic             AmaB;
   logic             AmeB;
   logic [2:0]       cond;
   logic             out_valid;
   logic             out_ready;
   logic             take;
   logic [2:0]       out_cond;
   logic             flag_err;
   logic [CNT_W-1:0] taken_cnt;

   modport master (
      output in_valid, AeqB, AmaB, AmeB, cond, out_ready,
      input  in_ready, out_valid, take, out_cond, flag_err, taken_cnt
   );

   modport slave (
      input  in_valid, AeqB, AmaB, AmeB, cond, out_ready,
      output in_ready, out_valid, take, out_cond, flag_err, taken_cnt
   );
endinterface

// File: rtl/rel_cond_unit.sv
// Evaluates a branch condition from comparator flags on entry and queues the decision in a small FIFO.
// Optional flag-triple legality checking is enabled with `define REL_FLAG_CHECK_EN.
module rel_cond_unit #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input logic          clk,
   input logic          rst,
   rel_cond_unit_if.slave bus
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   localparam logic [2:0] COND_EQ     = 3'd0;
   localparam logic [2:0] COND_NE     = 3'd1;
   localparam logic [2:0] COND_GT     = 3'd2;
   localparam logic [2:0] COND_LT     = 3'd3;
   localparam logic [2:0] COND_GE     = 3'd4;
   localparam logic [2:0] COND_LE     = 3'd5;
   localparam logic [2:0] COND_ALWAYS = 3'd6;

   typedef struct packed {
      logic       take;
      logic [2:0] cond;
      logic       err;
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           newEntry;
   entry_t           headNext;
   entry_t           headQ;
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W-1:0] rdNext;
   logic [OCC_W-1:0] occCnt;
   logic [OCC_W-1:0] occNext;
   logic [CNT_W-1:0] takenCnt;
   logic             inReadyQ;
   logic             outValidQ;
   logic             push;
   logic             pop;

   // Condition evaluation at the FIFO input
   always_comb begin
      newEntry      = '0;
      newEntry.cond = bus.cond;
      case (bus.cond)
         COND_EQ:     newEntry.take = bus.AeqB;
         COND_NE:     newEntry.take = !bus.AeqB;
         COND_GT:     newEntry.take = bus.AmaB;
         COND_LT:     newEntry.take = bus.AmeB;
         COND_GE:     newEntry.take = bus.AmaB | bus.AeqB;
         COND_LE:     newEntry.take = bus.AmeB | bus.AeqB;
         COND_ALWAYS: newEntry.take = 1'b1;
         default:     newEntry.take = 1'b0;
      endcase
`ifdef REL_FLAG_CHECK_EN
      newEntry.err = (2'(bus.AeqB) + 2'(bus.AmaB) + 2'(bus.AmeB)) != 2'd1;
      if (newEntry.err && (bus.cond != COND_ALWAYS)) begin
         newEntry.take = 1'b0;
      end
`endif
   end

   // Next pointer/occupancy and the entry that becomes head next cycle
   always_comb begin
      push     = bus.in_valid && inReadyQ;
      pop      = outValidQ && bus.out_ready;
      rdNext   = pop ? rdPtr + PTR_W'(1) : rdPtr;
      occNext  = occCnt + OCC_W'(push) - OCC_W'(pop);
      // Queue drains to zero this cycle, so a non-empty result means the new push is head
      headNext = (occCnt == OCC_W'(pop)) ? newEntry : mem[rdNext];
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wrPtr] <= newEntry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         occCnt    <= '0;
         headQ     <= '0;
         takenCnt  <= '0;
         inReadyQ  <= 1'b1;
         outValidQ <= 1'b0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + PTR_W'(1);
         end
         rdPtr     <= rdNext;
         occCnt    <= occNext;
         inReadyQ  <= occNext != OCC_W'(DEPTH);
         outValidQ <= occNext != '0;
         // Head outputs hold their last popped value while empty
         if (occNext != '0) begin
            headQ <= headNext;
         end
         if (pop && headQ.take && (takenCnt != '1)) begin
            takenCnt <= takenCnt + CNT_W'(1);
         end
      end
   end

   assign bus.in_ready  = inReadyQ;
   assign bus.out_valid = outValidQ;
   assign bus.take      = headQ.take;
   assign bus.out_cond  = headQ.cond;
   assign bus.flag_err  = headQ.err;
   assign bus.taken_cnt = takenCnt;
endmodule
